// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: interrupt cause codes, FSM state
// encodings and default datapath widths.
package trap_sequencer_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned DATA_WIDTH_DEF = 32;

    // Machine interrupt cause codes (low bits of mcause).
    localparam logic [3:0] M_EXTER_INT = 4'd11;
    localparam logic [3:0] M_SOFT_INT  = 4'd3;
    localparam logic [3:0] M_TIMER_INT = 4'd7;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StFlush   = 2'b01,
        StTake    = 2'b10,
        StHandler = 2'b11
    } state_e;

    // irq_v is {ext, sw, tmr}, already qualified by the enables.
    function automatic logic irq_code_qualified(input logic [3:0] code, input logic [2:0] irq_v);
        logic q;
        q = 1'b0;
        case (code)
            M_EXTER_INT: q = irq_v[2];
            M_SOFT_INT:  q = irq_v[1];
            M_TIMER_INT: q = irq_v[0];
            default:     q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/trap_prio_arb.sv
// Fixed-priority trap request picker: exception > external > software > timer.
// Purely combinational; reports whether anything won, its code and whether
// the winner is an interrupt.
module trap_prio_arb
    import trap_sequencer_pkg::*;
(
    input  logic       exc_req_i,
    input  logic [3:0] exc_code_i,
    input  logic [2:0] irq_v_i,      // {ext, sw, tmr}, qualified
    output logic       valid_o,
    output logic [3:0] code_o,
    output logic       is_irq_o
);

    // Priority pick of the highest pending source.
    always_comb begin
        valid_o  = 1'b1;
        is_irq_o = 1'b1;
        code_o   = 4'd0;
        if (exc_req_i) begin
            is_irq_o = 1'b0;
            code_o   = exc_code_i;
        end else if (irq_v_i[2]) begin
            code_o = M_EXTER_INT;
        end else if (irq_v_i[1]) begin
            code_o = M_SOFT_INT;
        end else if (irq_v_i[0]) begin
            code_o = M_TIMER_INT;
        end else begin
            valid_o  = 1'b0;
            is_irq_o = 1'b0;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry sequencer: picks a trap source, flushes the pipeline, emits a
// single trap_take pulse with cause and redirect vector, then tracks handler
// residency until mret.
// Optional feature: define TRAP_VECTORED_EN to honour vectored mtvec mode for
// interrupts; otherwise the vector is always mtvec_base.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int unsigned FLUSH_TIMEOUT = 15
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  exc_req,
    input  logic [3:0]            exc_code,
    input  logic                  irq_ext,
    input  logic                  irq_sw,
    input  logic                  irq_tmr,
    input  logic                  mstatus_mie,
    input  logic                  meie,
    input  logic                  msie,
    input  logic                  mtie,
    input  logic                  pipe_idle,
    input  logic                  mret,
    input  logic [ADDR_WIDTH-1:0] mtvec_base,
    input  logic [1:0]            mtvec_mode,
    output logic                  flush_req,
    output logic                  trap_take,
    output logic [DATA_WIDTH-1:0] trap_cause,
    output logic [ADDR_WIDTH-1:0] trap_vector,
    output logic                  in_trap,
    output logic                  flush_timeout
);

    localparam int unsigned CntW = (FLUSH_TIMEOUT < 2) ? 1 : $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FLUSH_TIMEOUT);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] cause_q, cause_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  in_trap_q, in_trap_d;
    logic [DATA_WIDTH-1:0] trap_cause_q, trap_cause_d;
    logic [ADDR_WIDTH-1:0] trap_vector_q, trap_vector_d;

    logic [2:0]            irq_v;
    logic                  arb_valid;
    logic [3:0]            arb_code;
    logic                  arb_irq;
    logic [DATA_WIDTH-1:0] arb_cause;
    logic [DATA_WIDTH-1:0] exc_cause;
    logic                  latched_irq;
    logic                  latched_qual;
    logic [ADDR_WIDTH-1:0] vec;

    assign irq_v = {mstatus_mie & meie & irq_ext,
                    mstatus_mie & msie & irq_sw,
                    mstatus_mie & mtie & irq_tmr};

    trap_prio_arb u_arb (
        .exc_req_i  (exc_req),
        .exc_code_i (exc_code),
        .irq_v_i    (irq_v),
        .valid_o    (arb_valid),
        .code_o     (arb_code),
        .is_irq_o   (arb_irq)
    );

    assign latched_irq  = cause_q[DATA_WIDTH-1];
    assign latched_qual = irq_code_qualified(cause_q[3:0], irq_v);

    // Build full mcause values for the arbiter winner and for a raw exception.
    always_comb begin
        arb_cause                 = '0;
        arb_cause[DATA_WIDTH-1]   = arb_irq;
        arb_cause[3:0]            = arb_code;
        exc_cause                 = '0;
        exc_cause[3:0]            = exc_code;
    end

    // Redirect target for the currently latched cause; low two bits always 0.
    always_comb begin
        vec = mtvec_base;
`ifdef TRAP_VECTORED_EN
        if (mtvec_mode == 2'b01 && cause_q[DATA_WIDTH-1]) begin
            vec = mtvec_base + ADDR_WIDTH'({cause_q[3:0], 2'b00});
        end
`endif
        vec[1:0] = 2'b00;
    end

`ifndef TRAP_VECTORED_EN
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec_mode;
`endif

    // Next-state logic for the sequencer FSM, flush counter and output registers.
    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        cnt_d         = cnt_q;
        timeout_d     = timeout_q;
        in_trap_d     = in_trap_q;
        trap_cause_d  = trap_cause_q;
        trap_vector_d = trap_vector_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (arb_valid) begin
                    cause_d = arb_cause;
                    state_d = StFlush;
                end
            end
            StFlush: begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
                if (cnt_d == CntMax) begin
                    timeout_d = 1'b1;
                end
                if (latched_irq && exc_req) begin
                    // Late exception displaces the interrupt; keep flushing.
                    cause_d = exc_cause;
                end else if (!exc_req && (!latched_irq || !latched_qual)) begin
                    // Request vanished before the pipe drained: abandon entry.
                    state_d   = StIdle;
                    cnt_d     = '0;
                    in_trap_d = 1'b0;
                end else if (pipe_idle) begin
                    state_d       = StTake;
                    cnt_d         = '0;
                    trap_cause_d  = cause_q;
                    trap_vector_d = vec;
                end
            end
            StTake: begin
                state_d   = StHandler;
                in_trap_d = 1'b1;
            end
            StHandler: begin
                // Nested exception beats a simultaneous mret.
                if (exc_req) begin
                    cause_d = exc_cause;
                    state_d = StFlush;
                end else if (mret) begin
                    state_d   = StIdle;
                    in_trap_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q       <= StIdle;
            cause_q       <= '0;
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
            in_trap_q     <= 1'b0;
            trap_cause_q  <= '0;
            trap_vector_q <= '0;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
            in_trap_q     <= in_trap_d;
            trap_cause_q  <= trap_cause_d;
            trap_vector_q <= trap_vector_d;
        end
    end

    assign flush_req     = (state_q == StFlush);
    assign trap_take     = (state_q == StTake);
    assign in_trap       = in_trap_q;
    assign trap_cause    = trap_cause_q;
    assign trap_vector   = trap_vector_q;
    assign flush_timeout = timeout_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: expected (cause, vector) pairs are queued
// when a trap is provoked and checked by a monitor whenever trap_take fires.
module tb_trap_sequencer;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        exc_req;
    logic [3:0]  exc_code;
    logic        irq_ext, irq_sw, irq_tmr;
    logic        mstatus_mie, meie, msie, mtie;
    logic        pipe_idle;
    logic        mret;
    logic [31:0] mtvec_base;
    logic [1:0]  mtvec_mode;
    logic        flush_req;
    logic        trap_take;
    logic [31:0] trap_cause;
    logic [31:0] trap_vector;
    logic        in_trap;
    logic        flush_timeout;

    localparam logic [31:0] VecBase = 32'h100;
`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] VecExt = 32'h12C;
    localparam logic [31:0] VecSw  = 32'h10C;
    localparam logic [31:0] VecTmr = 32'h11C;
`else
    localparam logic [31:0] VecExt = 32'h100;
    localparam logic [31:0] VecSw  = 32'h100;
    localparam logic [31:0] VecTmr = 32'h100;
`endif

    int total = 0;
    int bad   = 0;
    logic [63:0] sb_q[$];

    trap_sequencer dut (
        .cpu_clk       (cpu_clk),
        .cpu_rst       (cpu_rst),
        .exc_req       (exc_req),
        .exc_code      (exc_code),
        .irq_ext       (irq_ext),
        .irq_sw        (irq_sw),
        .irq_tmr       (irq_tmr),
        .mstatus_mie   (mstatus_mie),
        .meie          (meie),
        .msie          (msie),
        .mtie          (mtie),
        .pipe_idle     (pipe_idle),
        .mret          (mret),
        .mtvec_base    (mtvec_base),
        .mtvec_mode    (mtvec_mode),
        .flush_req     (flush_req),
        .trap_take     (trap_take),
        .trap_cause    (trap_cause),
        .trap_vector   (trap_vector),
        .in_trap       (in_trap),
        .flush_timeout (flush_timeout)
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic expect_trap(input logic [31:0] cause, input logic [31:0] vector);
        sb_q.push_back({cause, vector});
    endtask

    // Monitor: every trap_take must match the oldest queued expectation.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge cpu_clk);
            if (!cpu_rst && trap_take) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_take", trap_cause, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("take_cause", trap_cause, e[63:32]);
                    chk("take_vector", trap_vector, e[31:0]);
                end
            end
        end
    end

    initial begin
        cpu_rst = 1'b1;
        exc_req = 0; exc_code = 0;
        irq_ext = 0; irq_sw = 0; irq_tmr = 0;
        mstatus_mie = 1; meie = 1; msie = 1; mtie = 1;
        pipe_idle = 0; mret = 0;
        mtvec_base = VecBase; mtvec_mode = 2'b01;
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        chk("rst_flush_req", 32'(flush_req), 0);
        chk("rst_trap_take", 32'(trap_take), 0);
        chk("rst_in_trap", 32'(in_trap), 0);
        chk("rst_cause", trap_cause, 0);
        chk("rst_vector", trap_vector, 0);
        chk("rst_timeout", 32'(flush_timeout), 0);
        cyc();
        cpu_rst = 1'b0;

        // Direct exception, pipe already idle.
        exc_req = 1; exc_code = 4'd2; pipe_idle = 1;
        expect_trap(32'h0000_0002, VecBase);
        @(negedge cpu_clk);
        chk("exc_idle_no_flush", 32'(flush_req), 0);
        cyc();
        @(negedge cpu_clk);
        chk("exc_flush", 32'(flush_req), 1);
        chk("exc_flush_no_take", 32'(trap_take), 0);
        cyc();
        exc_req = 0;
        @(negedge cpu_clk);
        chk("exc_take_pulse", 32'(trap_take), 1);
        chk("exc_take_no_flush", 32'(flush_req), 0);
        chk("exc_take_not_in_trap", 32'(in_trap), 0);
        cyc();
        @(negedge cpu_clk);
        chk("exc_in_trap", 32'(in_trap), 1);
        chk("exc_take_once", 32'(trap_take), 0);
        mret = 1;
        cyc();
        mret = 0;
        @(negedge cpu_clk);
        chk("exc_mret_out", 32'(in_trap), 0);

        // Simultaneous interrupts: ext wins, then sw after ext clears.
        irq_ext = 1; irq_sw = 1; irq_tmr = 1;
        expect_trap(32'h8000_000B, VecExt);
        cyc(); cyc(); cyc();
        cyc(); cyc();
        @(negedge cpu_clk);
        chk("irq_handler_ignores", 32'(flush_req), 0);
        chk("irq_handler_in_trap", 32'(in_trap), 1);
        chk("irq_ext_drained", sb_q.size(), 0);
        irq_ext = 0; mret = 1;
        expect_trap(32'h8000_0003, VecSw);
        cyc();
        mret = 0;
        cyc(); cyc(); cyc();
        irq_sw = 0; irq_tmr = 0; mret = 1;
        cyc();
        mret = 0;
        chk("irq_sw_drained", sb_q.size(), 0);

        // Cancel during flush: timer enable drops before the pipe drains.
        pipe_idle = 0; irq_tmr = 1;
        cyc();
        @(negedge cpu_clk);
        chk("cancel_flush", 32'(flush_req), 1);
        cyc();
        mtie = 0;
        cyc();
        @(negedge cpu_clk);
        chk("cancel_idle", 32'(flush_req), 0);
        cyc(); cyc();
        @(negedge cpu_clk);
        chk("cancel_stays_idle", 32'(flush_req), 0);
        chk("cancel_no_trap", 32'(in_trap), 0);
        irq_tmr = 0; mtie = 1;

        // Exception overrides a latched timer interrupt.
        irq_tmr = 1;
        cyc();
        exc_req = 1; exc_code = 4'd11;
        expect_trap(32'h0000_000B, VecBase);
        cyc();
        @(negedge cpu_clk);
        chk("override_flush", 32'(flush_req), 1);
        pipe_idle = 1;
        cyc();
        exc_req = 0; irq_tmr = 0;
        cyc();
        @(negedge cpu_clk);
        chk("override_in_trap", 32'(in_trap), 1);

        // Nested exception with simultaneous mret: exception wins.
        exc_req = 1; exc_code = 4'd4; mret = 1;
        expect_trap(32'h0000_0004, VecBase);
        cyc();
        mret = 0;
        @(negedge cpu_clk);
        chk("nested_flush", 32'(flush_req), 1);
        chk("nested_in_trap", 32'(in_trap), 1);
        cyc();
        exc_req = 0;
        @(negedge cpu_clk);
        chk("nested_take_in_trap", 32'(in_trap), 1);
        cyc();
        mret = 1;
        cyc();
        mret = 0;
        @(negedge cpu_clk);
        chk("nested_out", 32'(in_trap), 0);

        // Flush timeout: pipe stays busy for 20 flush cycles.
        pipe_idle = 0; exc_req = 1; exc_code = 4'd5;
        expect_trap(32'h0000_0005, VecBase);
        cyc();
        @(negedge cpu_clk);
        chk("to_start", 32'(flush_timeout), 0);
        repeat (14) cyc();
        @(negedge cpu_clk);
        chk("to_cycle14", 32'(flush_timeout), 0);
        cyc();
        @(negedge cpu_clk);
        chk("to_cycle15", 32'(flush_timeout), 1);
        chk("to_still_flush", 32'(flush_req), 1);
        repeat (4) cyc();
        pipe_idle = 1;
        cyc();
        exc_req = 0;
        cyc();
        mret = 1;
        cyc();
        mret = 0;
        @(negedge cpu_clk);
        chk("to_sticky", 32'(flush_timeout), 1);

        // Vectored timer, then direct mode timer.
        irq_tmr = 1;
        expect_trap(32'h8000_0007, VecTmr);
        cyc(); cyc(); cyc();
        irq_tmr = 0; mret = 1;
        cyc();
        mret = 0;
        mtvec_mode = 2'b00; irq_tmr = 1;
        expect_trap(32'h8000_0007, VecBase);
        cyc(); cyc(); cyc();
        irq_tmr = 0; mret = 1;
        cyc();
        mret = 0;

        // Unaligned base: low bits forced to zero.
        mtvec_base = 32'h103; mtvec_mode = 2'b01;
        exc_req = 1; exc_code = 4'd0;
        expect_trap(32'h0000_0000, 32'h100);
        cyc(); cyc();
        exc_req = 0;
        cyc();
        mret = 1;
        cyc();
        mret = 0;
        mtvec_base = VecBase;
        chk("vec_drained", sb_q.size(), 0);

        // Reset during flush.
        pipe_idle = 0; exc_req = 1; exc_code = 4'd1;
        cyc();
        @(negedge cpu_clk);
        chk("rstmid_flush", 32'(flush_req), 1);
        #2 cpu_rst = 1'b1;
        #1;
        chk("rstmid_flush_clr", 32'(flush_req), 0);
        chk("rstmid_timeout_clr", 32'(flush_timeout), 0);
        exc_req = 0;
        cyc(); cyc();
        cpu_rst = 1'b0;
        cyc();
        @(negedge cpu_clk);
        chk("rstmid_idle", 32'(flush_req), 0);

        // Reset while in handler.
        exc_req = 1; exc_code = 4'd6; pipe_idle = 1;
        expect_trap(32'h0000_0006, VecBase);
        cyc(); cyc();
        exc_req = 0;
        cyc();
        @(negedge cpu_clk);
        chk("rsth_in_trap", 32'(in_trap), 1);
        #1 cpu_rst = 1'b1;
        #1;
        chk("rsth_in_trap_clr", 32'(in_trap), 0);
        cyc();
        cpu_rst = 1'b0;
        cyc(); cyc();

        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
